// File: rtl/input_debouncer.sv
// input_debouncer: per-channel switch/button conditioner.
// Every channel has a two-flop synchronizer, a stability counter that accepts a
// new level only after it has held for DEBOUNCE_CYCLES edges, one-cycle
// rise/fall pulses and a sticky rise-event flag that the bus clears.
module input_debouncer #(
    parameter int unsigned WIDTH           = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    localparam int unsigned CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    input  logic [WIDTH-1:0] clear_events,
    output logic [WIDTH-1:0] clean,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] events
);

    // Last count value before a differing level is accepted.
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [CNT_W-1:0] cnt   [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] clean_d;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_d;
    logic [WIDTH-1:0] events_d;

    // Next-state: count consecutive disagreeing edges, accept on the last one.
    always_comb begin
        clean_d = clean;
        rise_d  = '0;
        fall_d  = '0;
        cnt_d   = cnt;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (s2[i] == clean[i]) begin
                cnt_d[i] = '0;
            end else if (cnt[i] == CntMax) begin
                clean_d[i] = s2[i];
                cnt_d[i]   = '0;
                rise_d[i]  = s2[i];
                fall_d[i]  = ~s2[i];
            end else begin
                cnt_d[i] = cnt[i] + 1'b1;
            end
        end
        // A rise on the same edge as a clear keeps the flag set.
        events_d = (events & ~clear_events) | rise_d;
    end

    // State registers; reset discards any pending transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= '0;
            s2     <= '0;
            clean  <= '0;
            rise   <= '0;
            fall   <= '0;
            events <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1     <= raw;
            s2     <= s1;
            clean  <= clean_d;
            rise   <= rise_d;
            fall   <= fall_d;
            events <= events_d;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: scoreboard bench for input_debouncer (WIDTH=2,
// DEBOUNCE_CYCLES=4). The reference model keeps a window of sampled pin
// levels and accepts a level once the delayed window disagrees with the
// current clean level throughout.
module tb_input_debouncer;

    localparam int W = 2;
    localparam int D = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] raw;
    logic [W-1:0] clear_events;
    logic [W-1:0] clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] events;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] exp_q [$];

    input_debouncer #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .raw          (raw),
        .clear_events (clear_events),
        .clean        (clean),
        .rise         (rise),
        .fall         (fall),
        .events       (events)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare a packed {clean, rise, fall, events} word.
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: clean/rise/fall/events got %b/%b/%b/%b want %b/%b/%b/%b",
                     name, $time, act[7:6], act[5:4], act[3:2], act[1:0],
                     exp[7:6], exp[5:4], exp[3:2], exp[1:0]);
        end
    endtask

    // Inputs for the next rising edge, changed just after the falling edge.
    task automatic step(input logic [W-1:0] r, input logic [W-1:0] c);
        @(negedge clk);
        #1;
        raw          = r;
        clear_events = c;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // Reference model: hist[j] is the pin level sampled j edges ago.
    // The comparison at an edge sees the level sampled two edges earlier, so a
    // change is accepted when samples 2..D+1 all disagree with clean.
    logic [W-1:0] hist [D+2];
    logic [W-1:0] m_clean;
    logic [W-1:0] m_events;

    initial begin : model
        logic [W-1:0] acc;
        logic [W-1:0] m_rise;
        logic [W-1:0] m_fall;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                for (int j = 0; j < D + 2; j++) hist[j] = '0;
                m_clean  = '0;
                m_events = '0;
                exp_q.push_back(8'h00);
            end else begin
                for (int j = D + 1; j > 0; j--) hist[j] = hist[j-1];
                hist[0] = raw;
                acc = '1;
                for (int j = 2; j <= D + 1; j++) acc = acc & (hist[j] ^ m_clean);
                m_rise   = acc & ~m_clean;
                m_fall   = acc & m_clean;
                m_clean  = m_clean ^ acc;
                m_events = (m_events & ~clear_events) | m_rise;
                exp_q.push_back({m_clean, m_rise, m_fall, m_events});
            end
        end
    end

    // Monitor: every cycle presents an output word; compare at the falling edge.
    initial begin : monitor
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL scoreboard @%0t: no expected word queued", $time);
            end else begin
                exp = exp_q.pop_front();
                check("scoreboard", {clean, rise, fall, events}, exp);
            end
        end
    end

    initial begin : stim
        logic [W-1:0] r;
        logic [W-1:0] c;
        int bounce [5] = '{1, 0, 1, 1, 0};

        rst_n        = 1'b0;
        raw          = 2'b11;
        clear_events = 2'b00;

        // Reset with pins high, then release; edge 0 is the first edge after release.
        repeat (3) @(negedge clk);
        #1;
        check("reset_held", {clean, rise, fall, events}, 8'h00);
        rst_n = 1'b1;
        repeat (5) after_edge();
        check("rst_exit_pending", {clean, rise, fall, events}, 8'h00);
        after_edge();
        check("rst_exit_accept", {clean, rise, fall, events}, 8'b11_11_00_11);
        after_edge();
        check("rst_exit_pulse_end", {clean, rise, fall, events}, 8'b11_00_00_11);
        repeat (8) step(2'b00, 2'b00);
        step(2'b00, 2'b11);
        repeat (3) step(2'b00, 2'b00);

        // Clean press on channel 0.
        repeat (5) step(2'b01, 2'b00);
        after_edge();
        check("press_edge4", {clean, rise, fall, events}, 8'b00_00_00_00);
        after_edge();
        check("press_edge5", {clean, rise, fall, events}, 8'b01_01_00_01);
        after_edge();
        check("press_edge6", {clean, rise, fall, events}, 8'b01_00_00_01);

        // Release: fall pulse, event stays; then clear it.
        repeat (8) step(2'b00, 2'b00);
        step(2'b00, 2'b01);
        after_edge();
        check("clear_events", {clean, rise, fall, events}, 8'b00_00_00_00);

        // Glitch of 3 cycles must be rejected.
        repeat (3) step(2'b01, 2'b00);
        repeat (8) step(2'b00, 2'b00);
        check("glitch_rejected", {clean, rise, fall, events}, 8'b00_00_00_00);

        // Bounce, then settle high: accepted 5 edges after the last 0->1.
        foreach (bounce[i]) step(bounce[i] ? 2'b01 : 2'b00, 2'b00);
        repeat (5) step(2'b01, 2'b00);
        after_edge();
        check("bounce_edge4", {clean, rise, fall, events}, 8'b00_00_00_00);
        after_edge();
        check("bounce_edge5", {clean, rise, fall, events}, 8'b01_01_00_01);
        repeat (8) step(2'b00, 2'b00);
        step(2'b00, 2'b01);

        // Clear sampled on the accepting edge: set wins.
        repeat (5) step(2'b01, 2'b00);
        step(2'b01, 2'b01);
        after_edge();
        check("clear_vs_rise", {clean, rise, fall, events}, 8'b01_01_00_01);
        repeat (8) step(2'b00, 2'b00);
        step(2'b00, 2'b01);
        step(2'b00, 2'b00);

        // Reset two edges before acceptance of a press on channel 1.
        repeat (4) step(2'b10, 2'b00);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_mid_count", {clean, rise, fall, events}, 8'h00);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) step(2'b10, 2'b00);
        repeat (8) step(2'b00, 2'b00);

        // Randomized phase with occasional resets.
        r = 2'b00;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            #1;
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
                c[b] = ($urandom_range(0, 7) == 0);
            end
            raw          = r;
            clear_events = c;
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
        end
        rst_n = 1'b1;
        repeat (4) step(2'b00, 2'b00);
        @(posedge clk);
        #2;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
